// File: rtl/uart8n1_rx_os16.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority per bit, one-byte holding register
// behind a valid/ready handshake, with framing-error and overrun pulses.
module uart8n1_rx_os16 #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       rx_line,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_done,
  output logic       frame_err,
  output logic       overrun
);

  localparam int OS_DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state;
  logic          sync1, sync2;
  logic [TW-1:0] tick_cnt;
  logic [3:0]    os_cnt;
  logic [2:0]    bit_cnt;
  logic [1:0]    samp;
  logic [7:0]    shreg;
  logic          os_tick;
  logic          maj;

  // Tick counter only runs while a frame is being sampled.
  assign os_tick = (state == START || state == DATA || state == STOP) &&
                   (tick_cnt == TW'(OS_DIV - 1));
  // samp[1] and samp[0] hold the os_cnt 7 and 8 samples; the live line is the third vote.
  assign maj = (samp[1] & samp[0]) | (samp[1] & sync2) | (samp[0] & sync2);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      state     <= IDLE;
      tick_cnt  <= '0;
      os_cnt    <= '0;
      bit_cnt   <= '0;
      samp      <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync1     <= rx_line;
      sync2     <= sync1;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (!en) begin
        state    <= IDLE;
        rx_busy  <= 1'b0;
        tick_cnt <= '0;
        os_cnt   <= '0;
        bit_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            tick_cnt <= '0;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            if (!sync2) begin
              state   <= START;
              rx_busy <= 1'b1;
            end
          end
          BRK: begin
            if (sync2) state <= IDLE;
          end
          default: begin
            tick_cnt <= os_tick ? '0 : tick_cnt + TW'(1);
            if (os_tick) begin
              os_cnt <= os_cnt + 4'd1;
              if (os_cnt == 4'd7) samp[1] <= sync2;
              if (os_cnt == 4'd8) samp[0] <= sync2;
              if (os_cnt == 4'd9) begin
                case (state)
                  START: if (maj) begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                  end
                  DATA: shreg <= {maj, shreg[7:1]};
                  STOP: begin
                    rx_done   <= 1'b1;
                    frame_err <= ~maj;
                    if (!rx_valid || rx_ready) begin
                      rx_data  <= shreg;
                      rx_valid <= 1'b1;
                    end else begin
                      overrun <= 1'b1;
                    end
                    // Leaving mid stop bit lets a following start edge be caught immediately.
                    state   <= maj ? IDLE : BRK;
                    rx_busy <= 1'b0;
                  end
                  default: ;
                endcase
              end
              if (os_cnt == 4'd15) begin
                case (state)
                  START: state <= DATA;
                  DATA: begin
                    if (bit_cnt == 3'd7) state <= STOP;
                    else bit_cnt <= bit_cnt + 3'd1;
                  end
                  default: ;
                endcase
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart8n1_rx_os16.sv
// Directed bench for uart8n1_rx_os16: a bit-level serializer drives rx_line and a
// scoreboard of expected completions is checked by an independent monitor.
module tb_uart8n1_rx_os16;

  localparam int BIT = 432;

  logic       clk = 1'b0;
  logic       reset, en, rx_line, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, rx_done, frame_err, overrun;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       ovr;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   busy_seen   = 1'b0;

  uart8n1_rx_os16 dut (
    .clk(clk), .reset(reset), .en(en), .rx_line(rx_line), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy), .rx_done(rx_done),
    .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives the first nbits of a 10-bit frame: start, 8 data bits LSB first, stop.
  task automatic send(logic [7:0] d, logic stop, int nbits);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx_line = f[i];
      clks(BIT);
    end
  endtask

  // Monitor: outputs are sampled just after the rising edge.
  initial begin
    exp_t e;
    logic prev_hs;
    prev_hs = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        prev_hs = 1'b0;
      end else begin
        if (rx_busy) busy_seen = 1'b1;
        if (rx_done) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_rx_done: got rx_data %0h, no frame expected", rx_data);
          end else begin
            e = sb.pop_front();
            check("done_rx_data", rx_data, e.data);
            check("done_frame_err", frame_err, e.ferr);
            check("done_overrun", overrun, e.ovr);
            check("done_rx_valid", rx_valid, 1);
          end
        end else if (frame_err || overrun) begin
          check("stray_pulse", {frame_err, overrun}, 0);
        end
        if (prev_hs && !rx_done) check("hs_release", rx_valid, 0);
        prev_hs = rx_valid && rx_ready;
      end
    end
  end

  initial begin
    reset    = 1'b1;
    en       = 1'b1;
    rx_line  = 1'b1;
    rx_ready = 1'b1;
    clks(3);
    check("reset_outputs", {rx_data, rx_valid, rx_busy, rx_done, frame_err, overrun}, 0);
    reset = 1'b0;
    clks(5);

    // 1: plain frame, consumer ready
    sb.push_back('{data: 8'h48, ferr: 1'b0, ovr: 1'b0});
    send(8'h48, 1'b1, 10);
    clks(BIT);
    check("t1_rx_data", rx_data, 8'h48);
    check("t1_idle_busy", rx_busy, 0);

    // 2: short glitch is rejected, then a real frame
    busy_seen = 1'b0;
    rx_line = 1'b0;
    clks(81);
    rx_line = 1'b1;
    clks(2 * BIT);
    check("t2_busy_seen", busy_seen, 1);
    check("t2_busy_after", rx_busy, 0);
    sb.push_back('{data: 8'h65, ferr: 1'b0, ovr: 1'b0});
    send(8'h65, 1'b1, 10);
    clks(BIT);
    check("t2_rx_data", rx_data, 8'h65);

    // 3: stop bit low, line held low two more bit times
    sb.push_back('{data: 8'h55, ferr: 1'b1, ovr: 1'b0});
    send(8'h55, 1'b0, 10);
    clks(2 * BIT);
    rx_line = 1'b1;
    clks(2 * BIT);
    check("t3_rx_data", rx_data, 8'h55);

    // 4: consumer stalled, back-to-back frames overrun
    rx_ready = 1'b0;
    sb.push_back('{data: 8'hAA, ferr: 1'b0, ovr: 1'b0});
    sb.push_back('{data: 8'hAA, ferr: 1'b0, ovr: 1'b1});
    send(8'hAA, 1'b1, 10);
    send(8'hFF, 1'b1, 10);
    clks(BIT);
    check("t4_valid_held", rx_valid, 1);
    check("t4_rx_data_held", rx_data, 8'hAA);
    rx_ready = 1'b1;
    clks(2);
    check("t4_valid_drained", rx_valid, 0);
    check("t4_rx_data_kept", rx_data, 8'hAA);

    // 5: reset during data bits
    send(8'h33, 1'b1, 5);
    check("t5_busy_mid", rx_busy, 1);
    reset = 1'b1;
    clks(1);
    check("t5_reset_outputs", {rx_data, rx_valid, rx_busy, rx_done, frame_err, overrun}, 0);
    rx_line = 1'b1;
    reset = 1'b0;
    clks(BIT);
    sb.push_back('{data: 8'h00, ferr: 1'b0, ovr: 1'b0});
    send(8'h00, 1'b1, 10);
    clks(BIT);
    check("t5_rx_valid_cleared", rx_valid, 0);

    // 6: enable dropped mid frame
    send(8'hC3, 1'b1, 4);
    check("t6_busy_mid", rx_busy, 1);
    en = 1'b0;
    clks(3);
    check("t6_busy_aborted", rx_busy, 0);
    rx_line = 1'b1;
    clks(2 * BIT);
    en = 1'b1;
    clks(5);
    sb.push_back('{data: 8'h31, ferr: 1'b0, ovr: 1'b0});
    send(8'h31, 1'b1, 10);
    clks(BIT);
    check("t6_rx_data", rx_data, 8'h31);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
